systolic_output_collector: RTL and testbench
============================================

Name: systolic_output_collector

Overview:
- Receive end of the staggered streaming scheme used on the matrix-multiply input side.
- Input rows enter the systolic array column-skewed: column j is one cycle behind column j-1. Results leave the bottom of the array with the same skew.
- This block removes the skew, rebuilds complete result rows, and buffers them in a small FIFO. Downstream reads them with a valid/ready handshake.
- It counts rows per tile, reports busy/done, and flags overflow and misalignment.

Parameters:
N, 4, number of array columns (lanes per row)
DW, 16, data width per lane
ROWS, 4, result rows per tile before done
FIFO_DEPTH, 4, depth of the output row FIFO (power of two, >= 2)

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  asynchronous active-high reset
start  input  1  begin a tile; honoured only in IDLE
col_data  input  N*DW  lane j at bits [j*DW +: DW]; driven by array column j
col_valid  input  N  per-lane valid; lane j valid j cycles after lane 0 for the same row
out_data  output  N*DW  deskewed row, lane order as col_data
out_valid  output  1  FIFO head holds a row
out_ready  input  1  downstream accepts the row when out_valid && out_ready
busy  output  1  high in COLLECT and DRAIN
done  output  1  one-cycle pulse when a tile is fully delivered
overflow  output  1  sticky; a row was dropped because the FIFO was full
misalign  output  1  sticky; deskewed valid bits disagreed

Behaviour:
- Reset (asynchronous, any time, including mid-tile):
  - State goes to IDLE; row counter = 0; FIFO emptied; all deskew registers cleared.
  - Outputs: out_valid=0, out_data=0, busy=0, done=0, overflow=0, misalign=0.
- FSM states: IDLE, COLLECT, DRAIN, DONE.
  - IDLE: start=1 -> COLLECT; row_cnt <= 0; overflow and misalign cleared.
  - COLLECT: each aligned row increments row_cnt, whether pushed or dropped. When row_cnt reaches ROWS -> DRAIN.
  - DRAIN: FIFO empty -> DONE. Incoming col_valid is ignored.
  - DONE: done=1 for exactly one cycle -> IDLE.
  - start outside IDLE is ignored.
- Deskew pipeline:
  - Lane j (data plus valid) passes through N-1-j registers, so lane N-1 has zero delay.
  - Registers shift every cycle regardless of state.
- Alignment check:
  - Row-valid = AND of the deskewed valids.
  - If the deskewed valids are neither all 0 nor all 1 (any state other than IDLE): misalign <= 1, and nothing is pushed that cycle.
- Push rule:
  - Push occurs only in COLLECT with row-valid=1.
  - FIFO full and no pop in the same cycle: row dropped, overflow <= 1.
  - FIFO full and pop in the same cycle: push accepted, no overflow.
- Latency:
  - Lane 0 beat in cycle t, lane N-1 beat in cycle t+N-1.
  - The row is written at the end of cycle t+N-1; out_valid=1 in cycle t+N when the FIFO was empty (first-word fall-through).
- FIFO:
  - Pointers are log2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH.
  - Full and empty are distinguished by the pointer MSB.
  - out_data holds its value while out_valid && !out_ready.
  - out_data = 0 when the FIFO is empty.
  - Simultaneous push and pop on an empty FIFO: the push is written, the pop is ignored (nothing valid to pop).
- Arithmetic: row_cnt is clog2(ROWS+1) bits, saturating at ROWS.

Decomposition:
- Shared package (matmul_pkg):
  - collector state enum (IDLE/COLLECT/DRAIN/DONE);
  - default constants N, DW, ROWS, FIFO_DEPTH, shared with the input-side control.
- Sub-module: result_fifo, a synchronous FWFT FIFO.
  - Parameters: width N*DW, depth FIFO_DEPTH.
  - Ports: push, pop, full, empty, head data.
- Deskew registers and FSM stay in the top module.

Test Plan:
1. Single row, N=4: start, then lanes 0..3 valid in cycles 1..4 with values 0x11,0x22,0x33,0x44, out_ready=1 -> out_valid high only in cycle 5 with out_data={0x44,0x33,0x22,0x11}. Continue with 3 more rows back-to-back -> 4 rows out in order; done pulses once after the last pop; busy falls with done.
2. Back-pressure: out_ready=0 for the whole tile of 4 rows into a depth-4 FIFO -> FIFO full, no overflow, out_data stable on row 0. Release out_ready -> rows 0..3 pop on consecutive cycles, then done.
3. Overflow: FIFO_DEPTH=2, out_ready=0, push 4 rows -> rows 2 and 3 dropped; overflow=1 sticky; DRAIN after 2 pops; done.
4. Misalignment: drop lane 2 valid for one row -> misalign=1, that row not pushed, row_cnt unchanged; misalign clears on the next start.
5. Reset mid-tile: assert rst asynchronously after 2 rows pushed with out_ready=0 -> out_valid, busy, overflow and misalign = 0 immediately. Re-run scenario 1 -> correct output.
6. Full plus simultaneous pop: FIFO full, out_ready=1 in the same cycle a new row arrives -> row accepted, overflow stays 0.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix-multiply streaming blocks: default geometry
// and the output collector state encoding.
package matmul_pkg;

   localparam int DEF_N          = 4;
   localparam int DEF_DW         = 16;
   localparam int DEF_ROWS       = 4;
   localparam int DEF_FIFO_DEPTH = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      DRAIN   = 2'd2,
      DONE    = 2'd3
   } coll_state_e;

endpackage

// File: rtl/result_fifo.sv
// First-word fall-through row FIFO. The head reads as zero while empty; a pop
// on an empty FIFO is ignored and a push into a full FIFO is accepted only
// together with a pop.
module result_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic             full_o,
   output logic             empty_o,
   output logic [WIDTH-1:0] head_o
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wptr_q, wptr_d;
   logic [AW:0]      rptr_q, rptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push, do_pop;

   // Pointer MSB differs only when the write side has lapped the read side.
   assign empty_o = (wptr_q == rptr_q);
   assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   assign wptr_d = wptr_q + {{AW{1'b0}}, do_push};
   assign rptr_d = rptr_q + {{AW{1'b0}}, do_pop};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wptr_q[AW-1:0]] <= push_data_i;
      end
   end

   assign head_o = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

endmodule

// File: rtl/systolic_output_collector.sv
// Removes the column skew from systolic-array results, rebuilds full rows and
// queues them for a valid/ready consumer, tracking per-tile progress.
module systolic_output_collector
   import matmul_pkg::*;
#(
   parameter int N          = DEF_N,
   parameter int DW         = DEF_DW,
   parameter int ROWS       = DEF_ROWS,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [N*DW-1:0] col_data,
   input  logic [N-1:0]    col_valid,
   output logic [N*DW-1:0] out_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic            busy,
   output logic            done,
   output logic            overflow,
   output logic            misalign
);

   localparam int CW = $clog2(ROWS + 1);

   coll_state_e     state_q, state_d;
   logic [CW-1:0]   row_cnt_q, row_cnt_d;
   logic            overflow_q, overflow_d;
   logic            misalign_q, misalign_d;
   logic [N*DW-1:0] dsk_data;
   logic [N-1:0]    dsk_vld;
   logic            row_valid, row_partial, push_req;
   logic            fifo_push, fifo_pop, fifo_full, fifo_empty;

   // Lane j is delayed N-1-j cycles so every lane of a row lines up with lane N-1.
   for (genvar j = 0; j < N; j++) begin : g_lane
      localparam int D = N - 1 - j;
      if (D == 0) begin : g_pass
         assign dsk_data[j*DW +: DW] = col_data[j*DW +: DW];
         assign dsk_vld[j]           = col_valid[j];
      end else begin : g_dly
         logic [DW-1:0] data_q [D];
         logic [D-1:0]  vld_q;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int k = 0; k < D; k++) begin
                  data_q[k] <= '0;
               end
               vld_q <= '0;
            end else begin
               data_q[0] <= col_data[j*DW +: DW];
               vld_q[0]  <= col_valid[j];
               for (int k = 1; k < D; k++) begin
                  data_q[k] <= data_q[k-1];
                  vld_q[k]  <= vld_q[k-1];
               end
            end
         end

         assign dsk_data[j*DW +: DW] = data_q[D-1];
         assign dsk_vld[j]           = vld_q[D-1];
      end
   end

   assign row_valid   = &dsk_vld;
   assign row_partial = (|dsk_vld) && !row_valid;
   assign push_req    = (state_q == COLLECT) && row_valid;
   assign fifo_pop    = out_ready && !fifo_empty;
   assign fifo_push   = push_req && (!fifo_full || fifo_pop);

   result_fifo #(
      .WIDTH (N*DW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (fifo_push),
      .push_data_i (dsk_data),
      .pop_i       (fifo_pop),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .head_o      (out_data)
   );

   assign out_valid = !fifo_empty;

   always_comb begin
      row_cnt_d  = row_cnt_q;
      overflow_d = overflow_q;
      misalign_d = misalign_q;
      if (state_q == IDLE) begin
         if (start) begin
            row_cnt_d  = '0;
            overflow_d = 1'b0;
            misalign_d = 1'b0;
         end
      end else if (row_partial) begin
         misalign_d = 1'b1;
      end
      // Dropped rows still count toward the tile so the tile always terminates.
      if (push_req) begin
         if (row_cnt_q != CW'(ROWS)) begin
            row_cnt_d = row_cnt_q + CW'(1);
         end
         if (fifo_full && !fifo_pop) begin
            overflow_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         row_cnt_q  <= '0;
         overflow_q <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         row_cnt_q  <= row_cnt_d;
         overflow_q <= overflow_d;
         misalign_q <= misalign_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = COLLECT;
         COLLECT: if (row_cnt_d == CW'(ROWS)) state_d = DRAIN;
         DRAIN:   if (fifo_empty) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state_q)
         COLLECT, DRAIN: busy = 1'b1;
         DONE:           done = 1'b1;
         default:        ;
      endcase
   end

   assign overflow = overflow_q;
   assign misalign = misalign_q;

endmodule

// File: tb/tb_systolic_output_collector.sv
// Directed bench for the systolic output collector: a depth-4 and a depth-2
// instance share stimulus; each scenario checks cycle-exact expectations.
module tb_systolic_output_collector;

   localparam int N  = 4;
   localparam int DW = 16;

   logic            clk, rst, start, out_ready;
   logic [N*DW-1:0] col_data;
   logic [N-1:0]    col_valid;

   logic [N*DW-1:0] out_data, out_data2;
   logic            out_valid, busy, done, overflow, misalign;
   logic            out_valid2, busy2, done2, overflow2, misalign2;

   int ntests = 0;
   int nfail  = 0;

   systolic_output_collector #(.N(N), .DW(DW), .ROWS(4), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .start(start), .col_data(col_data), .col_valid(col_valid),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .busy(busy), .done(done), .overflow(overflow), .misalign(misalign)
   );

   systolic_output_collector #(.N(N), .DW(DW), .ROWS(4), .FIFO_DEPTH(2)) dut2 (
      .clk(clk), .rst(rst), .start(start), .col_data(col_data), .col_valid(col_valid),
      .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready),
      .busy(busy2), .done(done2), .overflow(overflow2), .misalign(misalign2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [DW-1:0] lane_val(input int r, input int j);
      return DW'(r * 256 + (j + 1) * 17);
   endfunction

   function automatic logic [N*DW-1:0] row_val(input int r);
      logic [N*DW-1:0] v;
      for (int j = 0; j < N; j++) v[j*DW +: DW] = lane_val(r, j);
      return v;
   endfunction

   // Drive one cycle: row r lane j is presented at feed cycle r+j.
   task automatic tick(input int fc, input int nrows, input int bad_row, input int bad_lane,
                       input logic st, input logic rdy);
      int r;
      @(posedge clk);
      #1;
      start     = st;
      out_ready = rdy;
      for (int j = 0; j < N; j++) begin
         r = fc - j;
         if (r >= 0 && r < nrows && !(r == bad_row && j == bad_lane)) begin
            col_valid[j]         = 1'b1;
            col_data[j*DW +: DW] = lane_val(r, j);
         end else begin
            col_valid[j]         = 1'b0;
            col_data[j*DW +: DW] = '0;
         end
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1; start = 1'b0; out_ready = 1'b0; col_valid = '0; col_data = '0;
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b1; out_ready = 1'b1; col_valid = '1; col_data = '1;
      #1;
      for (int i = 0; i < 2; i++) begin
         ntests++;
         if ({out_valid, busy, done, overflow, misalign} !== 5'b0 || out_data !== '0) begin
            nfail++;
            $display("FAIL reset_a i=%0d got v%b b%b d%b o%b m%b data=%h exp all 0",
                     i, out_valid, busy, done, overflow, misalign, out_data);
         end
         ntests++;
         if ({out_valid2, busy2, done2, overflow2, misalign2} !== 5'b0 || out_data2 !== '0) begin
            nfail++;
            $display("FAIL reset_b i=%0d got v%b b%b d%b o%b m%b data=%h exp all 0",
                     i, out_valid2, busy2, done2, overflow2, misalign2, out_data2);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_single_row(input string tag);
      logic            ev, eb;
      logic [N*DW-1:0] ed;
      do_reset();
      for (int c = 0; c <= 11; c++) begin
         tick(c - 1, 4, -1, -1, c == 0, 1'b1);
         ev = (c >= 5 && c <= 8);
         ed = ev ? row_val(c - 5) : '0;
         eb = (c >= 1 && c <= 9);
         ntests++;
         if (out_valid !== ev || out_data !== ed) begin
            nfail++;
            $display("FAIL %s_out c=%0d got v=%b d=%h exp v=%b d=%h", tag, c, out_valid, out_data, ev, ed);
         end
         ntests++;
         if (busy !== eb || done !== (c == 10)) begin
            nfail++;
            $display("FAIL %s_ctl c=%0d got busy=%b done=%b exp busy=%b done=%b", tag, c, busy, done, eb, c == 10);
         end
      end
   endtask

   task automatic test_backpressure();
      logic            ev;
      logic [N*DW-1:0] ed;
      do_reset();
      for (int c = 0; c <= 17; c++) begin
         tick(c - 1, 4, -1, -1, c == 0, c >= 11);
         ev = (c >= 5 && c <= 14);
         ed = !ev ? '0 : (c <= 10 ? row_val(0) : row_val(c - 11));
         ntests++;
         if (out_valid !== ev || out_data !== ed) begin
            nfail++;
            $display("FAIL bp_out c=%0d got v=%b d=%h exp v=%b d=%h", c, out_valid, out_data, ev, ed);
         end
         ntests++;
         if (overflow !== 1'b0 || done !== (c == 16) || busy !== (c >= 1 && c <= 15)) begin
            nfail++;
            $display("FAIL bp_ctl c=%0d got ovf=%b done=%b busy=%b exp ovf=0 done=%b busy=%b",
                     c, overflow, done, busy, c == 16, c >= 1 && c <= 15);
         end
      end
   endtask

   task automatic test_overflow();
      logic            ev;
      logic [N*DW-1:0] ed;
      do_reset();
      for (int c = 0; c <= 14; c++) begin
         tick(c - 1, 4, -1, -1, c == 0, c >= 10);
         ev = (c >= 5 && c <= 11);
         ed = !ev ? '0 : (c == 11 ? row_val(1) : row_val(0));
         ntests++;
         if (out_valid2 !== ev || out_data2 !== ed) begin
            nfail++;
            $display("FAIL ovf_out c=%0d got v=%b d=%h exp v=%b d=%h", c, out_valid2, out_data2, ev, ed);
         end
         ntests++;
         if (overflow2 !== (c >= 7) || done2 !== (c == 13)) begin
            nfail++;
            $display("FAIL ovf_ctl c=%0d got ovf=%b done=%b exp ovf=%b done=%b",
                     c, overflow2, done2, c >= 7, c == 13);
         end
      end
   endtask

   task automatic test_misalign();
      logic            ev, eb;
      logic [N*DW-1:0] ed;
      do_reset();
      for (int c = 0; c <= 14; c++) begin
         tick(c - 1, 5, 1, 2, (c == 0) || (c == 13), 1'b1);
         ev = (c == 5) || (c >= 7 && c <= 9);
         ed = !ev ? '0 : (c == 5 ? row_val(0) : row_val(c - 5));
         eb = (c >= 1 && c <= 10) || (c == 14);
         ntests++;
         if (out_valid !== ev || out_data !== ed) begin
            nfail++;
            $display("FAIL mis_out c=%0d got v=%b d=%h exp v=%b d=%h", c, out_valid, out_data, ev, ed);
         end
         ntests++;
         if (misalign !== (c >= 6 && c <= 13) || done !== (c == 11) || busy !== eb) begin
            nfail++;
            $display("FAIL mis_ctl c=%0d got mis=%b done=%b busy=%b exp mis=%b done=%b busy=%b",
                     c, misalign, done, busy, c >= 6 && c <= 13, c == 11, eb);
         end
      end
   endtask

   task automatic test_reset_midtile();
      do_reset();
      for (int c = 0; c <= 8; c++) tick(c - 1, 4, 0, 2, c == 0, 1'b0);
      ntests++;
      if (out_valid !== 1'b1 || busy !== 1'b1 || misalign !== 1'b1 || overflow2 !== 1'b1) begin
         nfail++;
         $display("FAIL midrst_pre got v=%b busy=%b mis=%b ovf2=%b exp 1 1 1 1",
                  out_valid, busy, misalign, overflow2);
      end
      #2 rst = 1'b1;
      #1;
      ntests++;
      if ({out_valid, busy, done, overflow, misalign} !== 5'b0 || out_data !== '0 ||
          {out_valid2, busy2, overflow2, misalign2} !== 4'b0) begin
         nfail++;
         $display("FAIL midrst_post got v=%b busy=%b done=%b ovf=%b mis=%b d=%h v2=%b busy2=%b ovf2=%b mis2=%b exp 0",
                  out_valid, busy, done, overflow, misalign, out_data, out_valid2, busy2, overflow2, misalign2);
      end
      @(posedge clk);
      #2 rst = 1'b0;
   endtask

   task automatic test_full_pop();
      logic            ev;
      logic [N*DW-1:0] ed;
      do_reset();
      for (int c = 0; c <= 12; c++) begin
         tick(c - 1, 4, -1, -1, c == 0, c >= 6);
         ev = (c >= 5 && c <= 9);
         ed = !ev ? '0 : (c <= 6 ? row_val(0) : row_val(c - 6));
         ntests++;
         if (out_valid2 !== ev || out_data2 !== ed) begin
            nfail++;
            $display("FAIL fullpop_out c=%0d got v=%b d=%h exp v=%b d=%h", c, out_valid2, out_data2, ev, ed);
         end
         ntests++;
         if (overflow2 !== 1'b0 || done2 !== (c == 11)) begin
            nfail++;
            $display("FAIL fullpop_ctl c=%0d got ovf=%b done=%b exp ovf=0 done=%b", c, overflow2, done2, c == 11);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_row("single");
      test_backpressure();
      test_overflow();
      test_misalign();
      test_reset_midtile();
      test_single_row("rerun");
      test_full_pop();
      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
